sw_debounce: RTL and testbench

Synchronizes and debounces the eight board slide switches before they reach the ones/zeros counting and 7-segment display stage. Each switch bit passes through a two-flop synchronizer and a per-bit stability counter. A bit's output updates only after its synchronized input has differed from the current output for `STABLE_CYCLES` consecutive clocks. The block also emits a one-cycle `changed` strobe, plus optional per-bit edge pulses, so downstream logic can react to updates without polling.

---
 rtl/sw_pkg.sv | 26 ++
 rtl/sw_debounce_bit.sv | 87 ++++++++
 rtl/sw_debounce.sv | 50 +++++
 tb/tb_sw_debounce.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and edge-classification helper for the slide-switch debouncer.
// The rise/fall outputs are built only when SW_DEBOUNCE_EDGE_EN is defined.
package sw_pkg;

  localparam int SW_WIDTH              = 8;
  localparam int DEFAULT_STABLE_CYCLES = 50000;
  localparam int DEFAULT_CNT_W         = 16;
  localparam int SIM_STABLE_CYCLES     = 4;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // The new output value is the synchronized input, so the edge direction follows it.
  function automatic edge_e classify_edge(input logic upd, input logic new_val);
    edge_e e;
    e = EDGE_NONE;
    if (upd) begin
      e = new_val ? EDGE_RISE : EDGE_FALL;
    end
    return e;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and debounced output flop.
// Optional registered rise/fall pulses when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic sw_out_o,
  output logic upd_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             out_q;
  logic             out_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             upd_d;

  // Any agreement between input and output restarts the count, so glitches leave no trace.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    upd_d = 1'b0;
    if (s2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s2_q;
      cnt_d = '0;
      upd_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      s1_q  <= sw_i;
      s2_q  <= s1_q;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign sw_out_o = out_q;
  assign upd_o    = upd_d;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic  rise_q;
  logic  fall_q;
  edge_e edge_d;

  always_comb begin
    edge_d = classify_edge(upd_d, s2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (edge_d == EDGE_RISE);
      fall_q <= (edge_d == EDGE_FALL);
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Debounces the board slide switches; one independent bit slice per switch.
// Edge pulses (rise/fall) are built only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_out,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] upd_d;
  logic             changed_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
      ) u_bit (
        .clk     (clk),
        .reset   (reset),
        .sw_i    (sw[gi]),
        .sw_out_o(sw_out[gi]),
        .upd_o   (upd_d[gi]),
        .rise_o  (rise[gi]),
        .fall_o  (fall[gi])
      );
    end
  endgenerate

  // Registered from the same next-state flags, so it lands on the edge the outputs update.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |upd_d;
    end
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4; edge expectations follow SW_DEBOUNCE_EDGE_EN.
module tb_sw_debounce;
  import sw_pkg::*;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] sw_out;
  logic       changed;
  logic [7:0] rise;
  logic [7:0] fall;

  int checks = 0;
  int errors = 0;

  sw_debounce #(
    .WIDTH        (SW_WIDTH),
    .STABLE_CYCLES(SIM_STABLE_CYCLES),
    .CNT_W        (DEFAULT_CNT_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .sw_out (sw_out),
    .changed(changed),
    .rise   (rise),
    .fall   (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then check all outputs 1 time unit later.
  task automatic step(input string tag, input logic [7:0] e_out, input logic e_ch,
                      input logic [7:0] e_rise, input logic [7:0] e_fall);
    logic [7:0] er;
    logic [7:0] ef;
    @(posedge clk);
    #1;
    er = EDGE_EN ? e_rise : 8'h00;
    ef = EDGE_EN ? e_fall : 8'h00;
    chk({tag, ".sw_out"}, sw_out, e_out);
    chk({tag, ".changed"}, {7'd0, changed}, {7'd0, e_ch});
    chk({tag, ".rise"}, rise, er);
    chk({tag, ".fall"}, fall, ef);
    $display("step %s: sw=%h sw_out=%h changed=%b rise=%h fall=%h",
             tag, sw, sw_out, changed, rise, fall);
  endtask

  task automatic quiet(input string tag, input int n, input logic [7:0] e_out);
    for (int i = 0; i < n; i++) step(tag, e_out, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'hFF;

    // Reset held three edges with switches high: everything stays 0.
    quiet("reset", 3, 8'h00);
    reset = 1'b0;
    // First sampling edge is the next one; update lands on the sixth.
    quiet("pwrup_wait", 5, 8'h00);
    step("pwrup_upd", 8'hFF, 1'b1, 8'hFF, 8'h00);
    quiet("pwrup_hold", 2, 8'hFF);

    // Upper nibble falls together: one changed pulse, fall=F0.
    sw = 8'h0F;
    quiet("ff_0f_wait", 5, 8'hFF);
    step("ff_0f_upd", 8'h0F, 1'b1, 8'h00, 8'hF0);
    quiet("ff_0f_hold", 1, 8'h0F);

    sw = 8'h00;
    quiet("to_zero_wait", 5, 8'h0F);
    step("to_zero_upd", 8'h00, 1'b1, 8'h00, 8'h0F);
    quiet("to_zero_hold", 1, 8'h00);

    // Three-cycle glitch on bit 0 is filtered out.
    sw = 8'h01;
    step("glitch_hi", 8'h00, 1'b0, 8'h00, 8'h00);
    step("glitch_hi", 8'h00, 1'b0, 8'h00, 8'h00);
    step("glitch_hi", 8'h00, 1'b0, 8'h00, 8'h00);
    sw = 8'h00;
    quiet("glitch_after", 8, 8'h00);

    // Bit 3 bounces 1,0,1,0 then holds 1.
    sw = 8'h08; step("bounce", 8'h00, 1'b0, 8'h00, 8'h00);
    sw = 8'h00; step("bounce", 8'h00, 1'b0, 8'h00, 8'h00);
    sw = 8'h08; step("bounce", 8'h00, 1'b0, 8'h00, 8'h00);
    sw = 8'h00; step("bounce", 8'h00, 1'b0, 8'h00, 8'h00);
    sw = 8'h08;
    quiet("bounce_wait", 5, 8'h00);
    step("bounce_upd", 8'h08, 1'b1, 8'h08, 8'h00);
    quiet("bounce_hold", 2, 8'h08);

    sw = 8'h00;
    quiet("clr_wait", 5, 8'h08);
    step("clr_upd", 8'h00, 1'b1, 8'h00, 8'h08);

    // Reset two cycles into a count discards it; full latency restarts after release.
    sw = 8'h01;
    quiet("midcnt_pre", 2, 8'h00);
    reset = 1'b1;
    quiet("midcnt_rst", 2, 8'h00);
    reset = 1'b0;
    quiet("midcnt_wait", 5, 8'h00);
    step("midcnt_upd", 8'h01, 1'b1, 8'h01, 8'h00);
    quiet("midcnt_hold", 2, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
